// File: rtl/ofs_plat_utils_fifo_pkg.sv
// Shared types and elaboration-time helpers for the single-clock FIFO.
package ofs_plat_utils_fifo_pkg;

  // Show-ahead prefetch pipeline states.
  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,  // output register empty
    SA_FETCH = 2'd1,  // RAM read in flight
    SA_VALID = 2'd2   // output register holds the head word
  } sa_state_e;

  // Plain constants for the state register, kept compatible with older
  // tools that dislike enum-typed state variables.
  localparam logic [1:0] ST_IDLE  = SA_IDLE;
  localparam logic [1:0] ST_FETCH = SA_FETCH;
  localparam logic [1:0] ST_VALID = SA_VALID;

  // Outcome of the parameter legality check.
  typedef enum logic {
    PARAMS_ILLEGAL = 1'b0,
    PARAMS_LEGAL   = 1'b1
  } param_check_e;

  // Largest depth radix for which the 32-bit shift stays well defined.
  localparam int MAX_DEPTH_RADIX = 30;

  // Validate a FIFO configuration before any size is derived from it.
  function automatic param_check_e check_fifo_params(
    input int data_width,
    input int depth_radix,
    input int almost_full_threshold,
    input int almost_empty_threshold,
    input int showahead
  );
    int depth;
    if (data_width < 1) return PARAMS_ILLEGAL;
    if (depth_radix < 1 || depth_radix > MAX_DEPTH_RADIX) return PARAMS_ILLEGAL;
    depth = 1 << depth_radix;
    if (almost_full_threshold < 0 || almost_full_threshold > depth - 1) return PARAMS_ILLEGAL;
    if (almost_empty_threshold < 0 || almost_empty_threshold > depth - 1) return PARAMS_ILLEGAL;
    if (showahead != 0 && showahead != 1) return PARAMS_ILLEGAL;
    return PARAMS_LEGAL;
  endfunction

endpackage

// File: rtl/ofs_plat_utils_sc_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface ofs_plat_utils_sc_fifo_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_RADIX = 9
);

  logic [DATA_WIDTH-1:0]  data;
  logic                   wrreq;
  logic                   rdreq;
  logic [DATA_WIDTH-1:0]  q;
  logic                   empty;
  logic                   full;
  logic                   almfull;
  logic                   almempty;
  logic [DEPTH_RADIX:0]   usedw;
  logic                   overflow;
  logic                   underflow;

  // Producer/consumer side: drives requests, observes data and status.
  modport master (
    output data, wrreq, rdreq,
    input  q, empty, full, almfull, almempty, usedw, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  data, wrreq, rdreq,
    output q, empty, full, almfull, almempty, usedw, overflow, underflow
  );

endinterface

// File: rtl/ofs_plat_utils_sc_fifo_ram.sv
// Simple dual-port storage: one write port, one read port whose data
// is registered one cycle after the read enable.
module ofs_plat_utils_sc_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; the output register clears so no stale word survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofs_plat_utils_sc_fifo.sv
// Single-clock FIFO with normal or show-ahead read, exact registered
// almost-full/almost-empty, full-range used-word count and sticky
// overflow/underflow flags.
module ofs_plat_utils_sc_fifo
  import ofs_plat_utils_fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = 32,
  parameter int DEPTH_RADIX            = 9,
  parameter int ALMOST_FULL_THRESHOLD  = 16,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter int SHOWAHEAD              = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  ofs_plat_utils_sc_fifo_if.slave fifo_if
);

  localparam int DEPTH = 1 << DEPTH_RADIX;
  localparam logic [DEPTH_RADIX:0] FULL_CNT = (DEPTH_RADIX+1)'(DEPTH);
  localparam logic [DEPTH_RADIX:0] AF_CNT   = (DEPTH_RADIX+1)'(DEPTH - ALMOST_FULL_THRESHOLD);
  localparam logic [DEPTH_RADIX:0] AE_CNT   = (DEPTH_RADIX+1)'(ALMOST_EMPTY_THRESHOLD);
  // Status flags reset to the values an empty FIFO would produce.
  localparam logic ALMFULL_RST  = (AF_CNT == '0);
  localparam logic ALMEMPTY_RST = 1'b1;

  generate
    if (check_fifo_params(DATA_WIDTH, DEPTH_RADIX, ALMOST_FULL_THRESHOLD,
                          ALMOST_EMPTY_THRESHOLD, SHOWAHEAD) != PARAMS_LEGAL) begin : g_bad_params
      $fatal(1, "ofs_plat_utils_sc_fifo: illegal parameter combination");
    end
  endgenerate

  logic                   write_acc;
  logic                   read_acc;
  logic [DEPTH_RADIX-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_RADIX:0]   count_q, count_d;
  logic                   empty_q, empty_d;
  logic                   full_q;
  logic                   almfull_q;
  logic                   almempty_q;
  logic                   overflow_q;
  logic                   underflow_q;

  logic                   ram_rd_en;
  logic [DEPTH_RADIX-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]  ram_rd_data;
  logic [DATA_WIDTH-1:0]  q_out;

  // Acceptance uses only registered status, so requests never reach outputs
  // combinationally. A read while full still frees a slot only next cycle.
  assign write_acc = fifo_if.wrreq & ~full_q;
  assign read_acc  = fifo_if.rdreq & ~empty_q;

  // Next write pointer and next occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_RADIX'(write_acc);
    count_d  = count_q + (DEPTH_RADIX+1)'(write_acc) - (DEPTH_RADIX+1)'(read_acc);
  end

  // Occupancy, write pointer and status flags, all taken from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      almfull_q   <= ALMFULL_RST;
      almempty_q  <= ALMEMPTY_RST;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= (count_d == FULL_CNT);
      almfull_q   <= (count_d >= AF_CNT);
      almempty_q  <= (count_d <= AE_CNT);
      overflow_q  <= overflow_q  | (fifo_if.wrreq & full_q);
      underflow_q <= underflow_q | (fifo_if.rdreq & empty_q);
    end
  end

  ofs_plat_utils_sc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_RADIX)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (write_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fifo_if.data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // The head word is prefetched into an output register. count_q includes
      // the word sitting in the fetch pipeline, so words still in the RAM are
      // count_q minus one whenever the pipeline is occupied.
      logic [1:0]             state_q, state_d;
      logic [DEPTH_RADIX-1:0] rd_ptr_q, rd_ptr_d;
      logic [DATA_WIDTH-1:0]  dout_q, dout_d;
      logic [DEPTH_RADIX:0]   pipe_cnt;
      logic                   ram_avail;
      logic                   fetch;

      assign pipe_cnt  = (DEPTH_RADIX+1)'(state_q != ST_IDLE);
      assign ram_avail = (count_q > pipe_cnt);

      // Prefetch state machine: keep the output register loaded whenever the
      // RAM holds an unfetched word.
      always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        fetch   = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (ram_avail) begin
              fetch   = 1'b1;
              state_d = ST_FETCH;
            end
          end
          ST_FETCH: begin
            dout_d  = ram_rd_data;
            state_d = ST_VALID;
          end
          ST_VALID: begin
            if (read_acc) begin
              if (ram_avail) begin
                fetch   = 1'b1;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
        rd_ptr_d = rd_ptr_q + DEPTH_RADIX'(fetch);
      end

      // Prefetch state, RAM read pointer and output register.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q  <= ST_IDLE;
          rd_ptr_q <= '0;
          dout_q   <= '0;
        end else begin
          state_q  <= state_d;
          rd_ptr_q <= rd_ptr_d;
          dout_q   <= dout_d;
        end
      end

      assign ram_rd_en   = fetch;
      assign ram_rd_addr = rd_ptr_q;
      // Empty tracks whether q holds a word, not whether usedw is zero.
      assign empty_d     = (state_d != ST_VALID);
      assign q_out       = dout_q;

    end else begin : g_normal
      // Normal mode: each accepted read loads the RAM output register, which
      // then holds until the next accepted read.
      logic [DEPTH_RADIX-1:0] rd_ptr_q, rd_ptr_d;

      assign rd_ptr_d = rd_ptr_q + DEPTH_RADIX'(read_acc);

      // RAM read pointer.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_ptr_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
        end
      end

      assign ram_rd_en   = read_acc;
      assign ram_rd_addr = rd_ptr_q;
      assign empty_d     = (count_d == '0);
      assign q_out       = ram_rd_data;
    end
  endgenerate

  assign fifo_if.q         = q_out;
  assign fifo_if.empty     = empty_q;
  assign fifo_if.full      = full_q;
  assign fifo_if.almfull   = almfull_q;
  assign fifo_if.almempty  = almempty_q;
  assign fifo_if.usedw     = count_q;
  assign fifo_if.overflow  = overflow_q;
  assign fifo_if.underflow = underflow_q;

endmodule

// File: tb/tb_ofs_plat_utils_sc_fifo.sv
// Directed bench for the single-clock FIFO: one instance per read mode,
// an 8-deep by 8-bit configuration, table-driven fill plus hand sequences.
module tb_ofs_plat_utils_sc_fifo;

  localparam int DW  = 8;
  localparam int DR  = 3;
  localparam int AFT = 2;
  localparam int AET = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_s;

  ofs_plat_utils_sc_fifo_if #(.DATA_WIDTH(DW), .DEPTH_RADIX(DR)) if_n ();
  ofs_plat_utils_sc_fifo_if #(.DATA_WIDTH(DW), .DEPTH_RADIX(DR)) if_s ();

  ofs_plat_utils_sc_fifo #(
    .DATA_WIDTH(DW), .DEPTH_RADIX(DR), .ALMOST_FULL_THRESHOLD(AFT),
    .ALMOST_EMPTY_THRESHOLD(AET), .SHOWAHEAD(0)
  ) dut_n (
    .clk     (clk),
    .reset   (rst_n),
    .fifo_if (if_n.slave)
  );

  ofs_plat_utils_sc_fifo #(
    .DATA_WIDTH(DW), .DEPTH_RADIX(DR), .ALMOST_FULL_THRESHOLD(AFT),
    .ALMOST_EMPTY_THRESHOLD(AET), .SHOWAHEAD(1)
  ) dut_s (
    .clk     (clk),
    .reset   (rst_s),
    .fifo_if (if_s.slave)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic       almfull;
    logic       almempty;
    logic [3:0] usedw;
    logic       overflow;
    logic       underflow;
  } obs_t;

  // One fill-table row: write stimulus and the status expected after the edge.
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic [3:0] usedw;
    logic       full;
    logic       almfull;
    logic       almempty;
    logic       ovf;
    logic       empty_n;
    logic       empty_s;
  } vec_t;

  vec_t fill_tab [9];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample(input bit sa);
    obs_t r;
    if (sa) begin
      r.q = if_s.q; r.empty = if_s.empty; r.full = if_s.full;
      r.almfull = if_s.almfull; r.almempty = if_s.almempty; r.usedw = if_s.usedw;
      r.overflow = if_s.overflow; r.underflow = if_s.underflow;
    end else begin
      r.q = if_n.q; r.empty = if_n.empty; r.full = if_n.full;
      r.almfull = if_n.almfull; r.almempty = if_n.almempty; r.usedw = if_n.usedw;
      r.overflow = if_n.overflow; r.underflow = if_n.underflow;
    end
    return r;
  endfunction

  task automatic drive(input bit sa, input logic rst, input logic wr, input logic rd,
                       input logic [7:0] d);
    if (sa) begin
      rst_s = rst; if_s.wrreq = wr; if_s.rdreq = rd; if_s.data = d;
    end else begin
      rst_n = rst; if_n.wrreq = wr; if_n.rdreq = rd; if_n.data = d;
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit sa);
    obs_t o;
    @(posedge clk);
    #1;
    o = sample(sa);
    $display("t=%0t %s rst=%0b wr=%0b rd=%0b d=%02h | q=%02h empty=%0b full=%0b af=%0b ae=%0b usedw=%0d ovf=%0b udf=%0b",
             $time, sa ? "SA" : "NM",
             sa ? rst_s : rst_n, sa ? if_s.wrreq : if_n.wrreq,
             sa ? if_s.rdreq : if_n.rdreq, sa ? if_s.data : if_n.data,
             o.q, o.empty, o.full, o.almfull, o.almempty, o.usedw, o.overflow, o.underflow);
  endtask

  task automatic do_reset(input bit sa);
    drive(sa, 1'b1, 1'b0, 1'b0, 8'h00);
    step(sa);
    step(sa);
    drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push(input bit sa, input logic [7:0] d);
    drive(sa, 1'b0, 1'b1, 1'b0, d);
    step(sa);
    drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Show-ahead: wait (bounded) until the head word is presented.
  task automatic wait_valid(input bit sa, input string name);
    obs_t w;
    int n;
    n = 0;
    w = sample(sa);
    while (w.empty && n < 6) begin
      step(sa);
      n++;
      w = sample(sa);
    end
    chk({name, "_timeout"}, 32'(w.empty), 32'd0);
  endtask

  bit   sa;
  obs_t o;

  initial begin
    //                 wr    d      usedw full  af    ae    ovf   empN  empS
    fill_tab[0] = '{1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    fill_tab[1] = '{1'b1, 8'h02, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fill_tab[2] = '{1'b1, 8'h03, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[3] = '{1'b1, 8'h04, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[4] = '{1'b1, 8'h05, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[5] = '{1'b1, 8'h06, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[6] = '{1'b1, 8'h07, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[7] = '{1'b1, 8'h08, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[8] = '{1'b1, 8'h09, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    for (int m = 0; m < 2; m++) begin
      sa = (m == 1);

      // Reset state.
      do_reset(sa);
      o = sample(sa);
      chk("rst_q", 32'(o.q), 32'h0);
      chk("rst_empty", 32'(o.empty), 32'd1);
      chk("rst_full", 32'(o.full), 32'd0);
      chk("rst_usedw", 32'(o.usedw), 32'd0);
      chk("rst_almfull", 32'(o.almfull), 32'd0);
      chk("rst_almempty", 32'(o.almempty), 32'd1);
      chk("rst_overflow", 32'(o.overflow), 32'd0);
      chk("rst_underflow", 32'(o.underflow), 32'd0);

      // Fill from the table, including the dropped ninth write.
      for (int i = 0; i < 9; i++) begin
        drive(sa, 1'b0, fill_tab[i].wr, 1'b0, fill_tab[i].d);
        step(sa);
        o = sample(sa);
        chk("fill_usedw", 32'(o.usedw), 32'(fill_tab[i].usedw));
        chk("fill_full", 32'(o.full), 32'(fill_tab[i].full));
        chk("fill_almfull", 32'(o.almfull), 32'(fill_tab[i].almfull));
        chk("fill_almempty", 32'(o.almempty), 32'(fill_tab[i].almempty));
        chk("fill_overflow", 32'(o.overflow), 32'(fill_tab[i].ovf));
        chk("fill_empty", 32'(o.empty), 32'(sa ? fill_tab[i].empty_s : fill_tab[i].empty_n));
      end
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);

      // Drain in order, then read once more while empty.
      if (!sa) begin
        drive(sa, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int j = 1; j <= 8; j++) begin
          step(sa);
          o = sample(sa);
          chk("drain_q", 32'(o.q), 32'(j));
          chk("drain_usedw", 32'(o.usedw), 32'(8 - j));
        end
      end else begin
        for (int j = 1; j <= 8; j++) begin
          wait_valid(sa, "drain_head");
          o = sample(sa);
          chk("drain_head_q", 32'(o.q), 32'(j));
          drive(sa, 1'b0, 1'b0, 1'b1, 8'h00);
          step(sa);
          drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
          o = sample(sa);
          chk("drain_usedw", 32'(o.usedw), 32'(8 - j));
        end
        step(sa);
        step(sa);
      end
      o = sample(sa);
      chk("drain_empty", 32'(o.empty), 32'd1);
      chk("drain_no_underflow", 32'(o.underflow), 32'd0);
      drive(sa, 1'b0, 1'b0, 1'b1, 8'h00);
      step(sa);
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      o = sample(sa);
      chk("underflow_set", 32'(o.underflow), 32'd1);
      chk("underflow_usedw", 32'(o.usedw), 32'd0);

      // Concurrent write+read at usedw=4, wrapping the pointers.
      do_reset(sa);
      for (int i = 0; i < 4; i++) push(sa, 8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
        if (sa) begin
          wait_valid(sa, "conc_head");
          o = sample(sa);
          chk("conc_head_q", 32'(o.q), 32'(8'h10 + i));
          drive(sa, 1'b0, 1'b1, 1'b1, 8'(8'h14 + i));
          step(sa);
          drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
        end else begin
          drive(sa, 1'b0, 1'b1, 1'b1, 8'(8'h14 + i));
          step(sa);
          o = sample(sa);
          chk("conc_q", 32'(o.q), 32'(8'h10 + i));
        end
        o = sample(sa);
        chk("conc_usedw", 32'(o.usedw), 32'd4);
      end
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      o = sample(sa);
      chk("conc_no_overflow", 32'(o.overflow), 32'd0);
      chk("conc_no_underflow", 32'(o.underflow), 32'd0);

      // Full with write+read: read taken, write dropped.
      do_reset(sa);
      for (int i = 0; i < 8; i++) push(sa, 8'(8'h20 + i));
      step(sa);
      step(sa);
      o = sample(sa);
      chk("bnd_full_before", 32'(o.full), 32'd1);
      drive(sa, 1'b0, 1'b1, 1'b1, 8'h55);
      step(sa);
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      o = sample(sa);
      chk("bnd_full_usedw", 32'(o.usedw), 32'd7);
      chk("bnd_full_overflow", 32'(o.overflow), 32'd1);
      chk("bnd_full_cleared", 32'(o.full), 32'd0);
      if (!sa) chk("bnd_full_q", 32'(o.q), 32'h20);

      // Empty with write+read: write taken, read ignored.
      do_reset(sa);
      drive(sa, 1'b0, 1'b1, 1'b1, 8'h66);
      step(sa);
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      o = sample(sa);
      chk("bnd_empty_usedw", 32'(o.usedw), 32'd1);
      chk("bnd_empty_underflow", 32'(o.underflow), 32'd1);
      chk("bnd_empty_overflow", 32'(o.overflow), 32'd0);
      if (sa) begin
        wait_valid(sa, "bnd_empty_head");
      end else begin
        drive(sa, 1'b0, 1'b0, 1'b1, 8'h00);
        step(sa);
        drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      o = sample(sa);
      chk("bnd_empty_q", 32'(o.q), 32'h66);

      // Reset in the middle of a fill.
      do_reset(sa);
      for (int i = 0; i < 5; i++) push(sa, 8'(8'h30 + i));
      o = sample(sa);
      chk("mid_usedw_before", 32'(o.usedw), 32'd5);
      drive(sa, 1'b1, 1'b0, 1'b0, 8'h00);
      step(sa);
      drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      o = sample(sa);
      chk("mid_usedw", 32'(o.usedw), 32'd0);
      chk("mid_empty", 32'(o.empty), 32'd1);
      chk("mid_q", 32'(o.q), 32'h0);
      push(sa, 8'hAA);
      if (sa) begin
        wait_valid(sa, "mid_head");
      end else begin
        drive(sa, 1'b0, 1'b0, 1'b1, 8'h00);
        step(sa);
        drive(sa, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      o = sample(sa);
      chk("mid_first_word", 32'(o.q), 32'hAA);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
